// File: rtl/veririsc_controller_if.sv
// Control bus between the VeriRISC sequencer and the rest of the CPU datapath.
// The master side is the controller; the slave side is the IR/ALU/PC/memory logic.
interface veririsc_controller_if;
    logic [2:0] opcode;
    logic       zero;
    logic       sel;
    logic       rd;
    logic       ld_ir;
    logic       inc_pc;
    logic       halt;
    logic       ld_pc;
    logic       data_e;
    logic       ld_ac;
    logic       wr;

    modport master (
        input  opcode, zero,
        output sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr
    );

    modport slave (
        output opcode, zero,
        input  sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr
    );
endinterface

// File: rtl/veririsc_controller.sv
// 8-phase VeriRISC instruction sequencer: steps fetch/execute phases and decodes
// the strobes for address mux, memory, IR, PC and accumulator from phase/opcode/zero.
module veririsc_controller (
    input  logic                  clk,
    input  logic                  rst,
    veririsc_controller_if.master bus
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    phase_t r_phase;
    phase_t w_phase_nxt;
    logic   r_halted;
    logic   w_halted_nxt;
    logic   w_aluop;
    logic   w_is_sto;
    logic   w_is_jmp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase  <= INST_ADDR;
            r_halted <= 1'b0;
        end else begin
            r_phase  <= w_phase_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    always_comb begin
        w_phase_nxt  = r_phase;
        w_halted_nxt = r_halted;
        w_aluop      = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                       (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);
        w_is_sto     = (bus.opcode == OP_STO);
        w_is_jmp     = (bus.opcode == OP_JMP);
        bus.sel      = 1'b0;
        bus.rd       = 1'b0;
        bus.ld_ir    = 1'b0;
        bus.inc_pc   = 1'b0;
        bus.halt     = 1'b0;
        bus.ld_pc    = 1'b0;
        bus.data_e   = 1'b0;
        bus.ld_ac    = 1'b0;
        bus.wr       = 1'b0;

        if (r_halted) begin
            // Frozen in OP_ADDR; only reset releases the sequencer.
            bus.halt = 1'b1;
        end else begin
            if (r_phase == OP_ADDR && bus.opcode == OP_HLT) begin
                w_halted_nxt = 1'b1;
            end else begin
                w_phase_nxt = phase_t'(r_phase + 3'd1);
            end

            case (r_phase)
                INST_ADDR: begin
                    bus.sel = 1'b1;
                end
                INST_FETCH: begin
                    bus.sel = 1'b1;
                    bus.rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    bus.sel   = 1'b1;
                    bus.rd    = 1'b1;
                    bus.ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    bus.halt   = (bus.opcode == OP_HLT);
                    bus.inc_pc = (bus.opcode != OP_HLT);
                end
                OP_FETCH: begin
                    bus.rd = w_aluop;
                end
                ALU_OP: begin
                    // Skip taken by a second PC increment; data_e starts early for write setup.
                    bus.rd     = w_aluop;
                    bus.inc_pc = (bus.opcode == OP_SKZ) && bus.zero;
                    bus.ld_pc  = w_is_jmp;
                    bus.data_e = w_is_sto;
                end
                STORE: begin
                    bus.rd     = w_aluop;
                    bus.ld_ac  = w_aluop;
                    bus.ld_pc  = w_is_jmp;
                    bus.wr     = w_is_sto;
                    bus.data_e = w_is_sto;
                end
                default: begin
                    bus.sel = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_veririsc_controller.sv
// Scoreboard bench for the VeriRISC sequencer: a reference model predicts the
// strobes and phase each cycle, pushes them to a queue and compares at negedge.
module tb_veririsc_controller;

    logic clk;
    logic rst;

    veririsc_controller_if bus ();

    veririsc_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] ph;
        logic [8:0] outs;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk;
    int   n_fail;

    logic [2:0] m_phase;
    logic       m_halted;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference strobes, bit order {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr}.
    function automatic logic [8:0] ref_outs(input logic [2:0] ph, input logic [2:0] op,
                                            input logic z, input logic h);
        logic sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
        logic alu;
        sel = 0; rd = 0; ld_ir = 0; inc_pc = 0; halt = 0;
        ld_pc = 0; data_e = 0; ld_ac = 0; wr = 0;
        alu = (op >= 3'd2) && (op <= 3'd5);
        if (h) begin
            halt = 1;
        end else begin
            case (ph)
                3'd0: sel = 1;
                3'd1: begin sel = 1; rd = 1; end
                3'd2, 3'd3: begin sel = 1; rd = 1; ld_ir = 1; end
                3'd4: if (op == 3'd0) halt = 1; else inc_pc = 1;
                3'd5: rd = alu;
                3'd6: begin
                    rd = alu; inc_pc = (op == 3'd1) & z;
                    ld_pc = (op == 3'd7); data_e = (op == 3'd6);
                end
                default: begin
                    rd = alu; ld_ac = alu; ld_pc = (op == 3'd7);
                    wr = (op == 3'd6); data_e = (op == 3'd6);
                end
            endcase
        end
        return {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};
    endfunction

    // One clock: drive inputs, predict, compare at negedge, advance the model after posedge.
    task automatic step(input logic [2:0] op, input logic z, input logic r);
        exp_t e;
        logic [8:0] obs;
        bus.opcode = op;
        bus.zero   = z;
        rst        = r;
        exp_q.push_back('{op: op, ph: m_phase, outs: ref_outs(m_phase, op, z, m_halted)});
        @(negedge clk);
        e   = exp_q.pop_front();
        obs = {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.halt,
               bus.ld_pc, bus.data_e, bus.ld_ac, bus.wr};
        check($sformatf("outs_op%0d_ph%0d", e.op, e.ph), 32'(obs), 32'(e.outs));
        check($sformatf("phase_op%0d", e.op), 32'(dut.r_phase), 32'(e.ph));
        @(posedge clk);
        #1;
        if (r) begin
            m_phase  = 3'd0;
            m_halted = 1'b0;
        end else if (!m_halted) begin
            if (m_phase == 3'd4 && op == 3'd0) m_halted = 1'b1;
            else m_phase = m_phase + 3'd1;
        end
    endtask

    // Full instruction; phases 0-3 see random opcode/zero when scramble is set.
    task automatic run_instr(input logic [2:0] op, input logic z, input logic scramble);
        for (int p = 0; p < 8; p++) begin
            if (scramble && p < 4) step(3'($urandom_range(7)), 1'($urandom_range(1)), 1'b0);
            else step(op, z, 1'b0);
        end
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        bus.opcode = 3'd2;
        bus.zero   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_phase  = 3'd0;
        m_halted = 1'b0;

        // Reset state, then one ADD cycle back to phase 0.
        run_instr(3'd2, 1'b0, 1'b0);
        run_instr(3'd2, 1'b1, 1'b1);
        run_instr(3'd6, 1'b0, 1'b0);
        run_instr(3'd1, 1'b1, 1'b0);
        run_instr(3'd1, 1'b0, 1'b1);
        run_instr(3'd3, 1'b1, 1'b0);
        run_instr(3'd4, 1'b0, 1'b1);
        run_instr(3'd5, 1'b0, 1'b0);
        run_instr(3'd7, 1'b1, 1'b0);
        run_instr(3'd6, 1'b1, 1'b1);

        // Reset in phase 5 of a JMP.
        for (int p = 0; p < 5; p++) step(3'd7, 1'b0, 1'b0);
        step(3'd7, 1'b0, 1'b1);
        step(3'd7, 1'b0, 1'b0);
        for (int p = 1; p < 8; p++) step(3'd7, 1'b0, 1'b0);

        // HLT, then 20 halted cycles with changing opcode, then reset out of halt.
        for (int p = 0; p < 4; p++) step(3'd0, 1'b0, 1'b0);
        step(3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(3'd2, 1'($urandom_range(1)), 1'b0);
        step(3'd2, 1'b1, 1'b1);
        run_instr(3'd2, 1'b0, 1'b0);
        run_instr(3'd1, 1'b1, 1'b1);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
